// File: rtl/add_4_pkg.sv
// Shared types and defaults for the registered ripple-carry adder.
package add_4_pkg;

  localparam int ADD_WIDTH = 4;

  // Full adder result at the default width: carry-out on top of the sum bits.
  typedef struct packed {
    logic                 cout;
    logic [ADD_WIDTH-1:0] sum;
  } add_res_t;

endpackage

// File: rtl/add_4_full_adder.sv
// One-bit full adder, purely combinational; chained by add_4 into a ripple adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/add_4.sv
// Registered ripple-carry adder: {Cout,Sum} = A + B + Cin, one cycle latency, no backpressure.
// Sum/Cout hold when in_valid is low; out_valid marks a freshly captured result.
module add_4
  import add_4_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             vld_d, vld_q;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a   (A[i]),
      .b   (B[i]),
      .cin (carry[i]),
      .s   (sum_d[i]),
      .cout(carry[i+1])
    );
  end

  assign cout_d = carry[WIDTH];
  assign vld_d  = in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_add_4.sv
// Self-checking bench for add_4: directed scenarios plus random traffic against an arithmetic model.
module tb_add_4;
  import add_4_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] A, B;
  logic       Cin, in_valid;
  logic [3:0] Sum;
  logic       Cout, out_valid;

  int checks = 0;
  int errors = 0;

  // Reference state: last captured result and whether the last edge saw a valid input.
  add_res_t m_res;
  logic     m_vld;

  add_4 #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .in_valid (in_valid),
    .Sum      (Sum),
    .Cout     (Cout),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one input set, clock it in, and settle 1 time unit past the edge.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
    A = a; B = b; Cin = c; in_valid = v;
    @(posedge clk);
    if (v) m_res = 5'(a) + 5'(b) + 5'(c);
    m_vld = v;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    A = 4'hF; B = 4'hF; Cin = 1'b1; in_valid = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({Cout, Sum, out_valid} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold: got cout=%b sum=%b vld=%b want all zero", Cout, Sum, out_valid);
      end
    end
    rst_n = 1'b1;
    m_res = '0; m_vld = 1'b0;
    drive(4'hF, 4'hF, 1'b1, 1'b1);
    checks++;
    if ({Cout, Sum, out_valid} !== {1'b1, 4'hF, 1'b1}) begin
      errors++;
      $display("FAIL reset_first_capture: got cout=%b sum=%b vld=%b want 1 1111 1", Cout, Sum, out_valid);
    end
  endtask

  task automatic test_double_sweep(input logic c);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kk;
      logic [4:0] want;
      kk = 4'(k);
      want = {(k >= 8) ? 1'b1 : 1'b0, 4'((2 * k + int'(c)) % 16)};
      drive(kk, kk, c, 1'b1);
      checks++;
      if ({Cout, Sum, out_valid} !== {want, 1'b1}) begin
        errors++;
        $display("FAIL double_sweep cin=%0b k=%0d: got cout=%b sum=%b vld=%b want %b %b 1",
                 c, k, Cout, Sum, out_valid, want[4], want[3:0]);
      end
    end
  endtask

  task automatic test_carry_propagate();
    drive(4'hF, 4'h0, 1'b1, 1'b1);
    checks++;
    if ({Cout, Sum, out_valid} !== {1'b1, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL carry_propagate: got cout=%b sum=%b vld=%b want 1 0000 1", Cout, Sum, out_valid);
    end
  endtask

  task automatic test_hold_latency();
    drive(4'h3, 4'h5, 1'b0, 1'b1);
    checks++;
    if ({Cout, Sum, out_valid} !== {1'b0, 4'h8, 1'b1}) begin
      errors++;
      $display("FAIL latency: got cout=%b sum=%b vld=%b want 0 1000 1", Cout, Sum, out_valid);
    end
    drive(4'hF, 4'h5, 1'b0, 1'b0);
    checks++;
    if ({Cout, Sum, out_valid} !== {1'b0, 4'h8, 1'b0}) begin
      errors++;
      $display("FAIL hold: got cout=%b sum=%b vld=%b want 0 1000 0", Cout, Sum, out_valid);
    end
    // Input changes between edges must not reach the outputs.
    A = 4'hA; B = 4'hA; Cin = 1'b1; in_valid = 1'b1;
    #2;
    checks++;
    if ({Cout, Sum, out_valid} !== {1'b0, 4'h8, 1'b0}) begin
      errors++;
      $display("FAIL between_edges: got cout=%b sum=%b vld=%b want 0 1000 0", Cout, Sum, out_valid);
    end
  endtask

  task automatic test_async_reset();
    drive(4'h7, 4'h7, 1'b0, 1'b1);
    checks++;
    if ({Cout, Sum, out_valid} !== {1'b0, 4'hE, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset: got cout=%b sum=%b vld=%b want 0 1110 1", Cout, Sum, out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({Cout, Sum, out_valid} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got cout=%b sum=%b vld=%b want all zero", Cout, Sum, out_valid);
    end
    #1 rst_n = 1'b1;
    m_res = '0; m_vld = 1'b0;
    drive(4'h9, 4'h8, 1'b1, 1'b1);
    checks++;
    if ({Cout, Sum, out_valid} !== {1'b1, 4'h2, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_capture: got cout=%b sum=%b vld=%b want 1 0010 1", Cout, Sum, out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      checks++;
      if ({Cout, Sum, out_valid} !== {m_res, m_vld}) begin
        errors++;
        $display("FAIL random[%0d]: got cout=%b sum=%b vld=%b want %b %b %b",
                 n, Cout, Sum, out_valid, m_res.cout, m_res.sum, m_vld);
      end
    end
  endtask

  initial begin
    test_reset();
    test_double_sweep(1'b0);
    test_double_sweep(1'b1);
    test_carry_propagate();
    test_hold_latency();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
